// File: rtl/sh4a_pkg.sv
// Shared constants and types for the SH-4A general-register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sh4a_pkg;

    localparam logic [31:0] SH4A_RESET_PC = 32'hA000_0000;

    // Physical slot layout: bank 0, then the globals R8..R15, then bank 1.
    localparam logic [4:0] BANK0_BASE  = 5'd0;
    localparam logic [4:0] GLOBAL_BASE = 5'd8;
    localparam logic [4:0] BANK1_BASE  = 5'd16;
    localparam int         NUM_PHYS    = 24;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } regfile_state_t;

endpackage

// File: rtl/sh4a_bank_map.sv
// Logical -> physical register index mapper for the banked SH-4A register file.
// Latency: purely combinational.
// Backpressure: none.
// Ports: idx (5-bit logical index), rb (SR.RB), phys (5-bit physical slot), legal.
module sh4a_bank_map
    import sh4a_pkg::*;
(
    input  logic [4:0] idx,
    input  logic       rb,
    output logic [4:0] phys,
    output logic       legal
);

    always_comb begin
        // Indices 24..31 have no register behind them.
        legal = !(idx[4] && idx[3]);
        phys  = GLOBAL_BASE + {2'b00, idx[2:0]};
        if (!idx[3]) begin
            // R0..R7 follow rb; Rn_BANK (idx 16..23) names the opposite bank.
            phys = ((idx[4] ^ rb) ? BANK1_BASE : BANK0_BASE) + {2'b00, idx[2:0]};
        end else if (idx[4]) begin
            // Illegal: park on slot 0; callers gate on legal.
            phys = BANK0_BASE;
        end
    end

endmodule

// File: rtl/sh4a_banked_regfile.sv
// SH-4A banked general-register file with N read ports, write bypass, post-reset clear and PC.
// Latency: reads registered, 1 cycle; same-cycle writes are forwarded to matching read ports.
// Backpressure: busy is high while the 24-cycle clear runs; the core must stall, writes are dropped.
// Ports: clk, reset (async, active-high), rb, rd_idx/rd_data (NUM_RD packed ports),
//        wr_en/wr_idx/wr_data, pc_load/pc_inc/pc_next/pc, busy, illegal.
module sh4a_banked_regfile
    import sh4a_pkg::*;
#(
    parameter int                 DATA_W   = 32,
    parameter int                 NUM_RD   = 2,
    parameter logic [DATA_W-1:0]  RESET_PC = DATA_W'(SH4A_RESET_PC)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rb,
    input  logic [5*NUM_RD-1:0]      rd_idx,
    output logic [DATA_W*NUM_RD-1:0] rd_data,
    input  logic                     wr_en,
    input  logic [4:0]               wr_idx,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     pc_load,
    input  logic                     pc_inc,
    input  logic [DATA_W-1:0]        pc_next,
    output logic [DATA_W-1:0]        pc,
    output logic                     busy,
    output logic                     illegal
);

    regfile_state_t    state, state_nxt;
    logic [4:0]        clr_cnt;
    logic              clr_we;

    logic [DATA_W-1:0] regs [NUM_PHYS];
    logic [NUM_PHYS-1:0] slot_we;
    logic [DATA_W-1:0] slot_d;

    logic [4:0]        rd_phys  [NUM_RD];
    logic              rd_legal [NUM_RD];
    logic [4:0]        wr_phys;
    logic              wr_legal;
    logic              wr_ok;
    logic              any_illegal;

    // Address mappers: one per read port plus one for the write port.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_map
        sh4a_bank_map u_rd_map (
            .idx   (rd_idx[5*k +: 5]),
            .rb    (rb),
            .phys  (rd_phys[k]),
            .legal (rd_legal[k])
        );
    end

    sh4a_bank_map u_wr_map (
        .idx   (wr_idx),
        .rb    (rb),
        .phys  (wr_phys),
        .legal (wr_legal)
    );

    // State register and clear counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= CLEAR;
            clr_cnt <= 5'd0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR) begin
                clr_cnt <= clr_cnt + 5'd1;
            end
        end
    end

    // Next-state logic: leave CLEAR on the edge that zeroes the last slot.
    always_comb begin
        state_nxt = state;
        if (state == CLEAR && clr_cnt == 5'(NUM_PHYS - 1)) begin
            state_nxt = RUN;
        end
    end

    // State-decoded outputs.
    always_comb begin
        busy   = (state == CLEAR);
        clr_we = (state == CLEAR);
    end

    assign wr_ok = wr_en && wr_legal && !busy;

    // Per-slot write enables: the sequencer owns the array while clearing.
    always_comb begin
        slot_d = clr_we ? '0 : wr_data;
        for (int i = 0; i < NUM_PHYS; i++) begin
            slot_we[i] = clr_we ? (clr_cnt == 5'(i)) : (wr_ok && wr_phys == 5'(i));
        end
    end

    // Flop array, deliberately unreset: the clear sequencer zeroes it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PHYS; i++) begin
            if (slot_we[i]) begin
                regs[i] <= slot_d;
            end
        end
    end

    always_comb begin
        any_illegal = wr_en && !wr_legal;
        for (int k = 0; k < NUM_RD; k++) begin
            any_illegal = any_illegal || !rd_legal[k];
        end
    end

    // Read ports with write-to-read bypass on physical slot match.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
            illegal <= 1'b0;
        end else if (busy) begin
            rd_data <= '0;
            illegal <= 1'b0;
        end else begin
            illegal <= any_illegal;
            for (int k = 0; k < NUM_RD; k++) begin
                if (!rd_legal[k]) begin
                    rd_data[k*DATA_W +: DATA_W] <= '0;
                end else if (wr_ok && wr_phys == rd_phys[k]) begin
                    rd_data[k*DATA_W +: DATA_W] <= wr_data;
                end else begin
                    rd_data[k*DATA_W +: DATA_W] <= regs[rd_phys[k]];
                end
            end
        end
    end

    // Program counter; runs independently of the clear sequencer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (pc_load) begin
            pc <= pc_next;
        end else if (pc_inc) begin
            pc <= pc + DATA_W'(2);
        end
    end

endmodule

// File: tb/tb_sh4a_banked_regfile.sv
// Directed self-checking bench for sh4a_banked_regfile (DATA_W=32, NUM_RD=2).
// Latency: n/a.
// Backpressure: n/a.
module tb_sh4a_banked_regfile;

    logic        clk;
    logic        reset;
    logic        rb;
    logic [9:0]  rd_idx;
    logic [63:0] rd_data;
    logic        wr_en;
    logic [4:0]  wr_idx;
    logic [31:0] wr_data;
    logic        pc_load;
    logic        pc_inc;
    logic [31:0] pc_next;
    logic [31:0] pc;
    logic        busy;
    logic        illegal;

    int n_chk  = 0;
    int n_pass = 0;

    sh4a_banked_regfile #(
        .DATA_W   (32),
        .NUM_RD   (2),
        .RESET_PC (32'hA000_0000)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .rb      (rb),
        .rd_idx  (rd_idx),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .pc_load (pc_load),
        .pc_inc  (pc_inc),
        .pc_next (pc_next),
        .pc      (pc),
        .busy    (busy),
        .illegal (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [4:0] i0, input logic [4:0] i1);
        rd_idx = {i1, i0};
    endtask

    task automatic wr(input logic [4:0] idx, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_idx  = idx;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    initial begin
        int cyc;
        reset   = 1'b1;
        rb      = 1'b0;
        rd_idx  = '0;
        wr_en   = 1'b0;
        wr_idx  = '0;
        wr_data = '0;
        pc_load = 1'b0;
        pc_inc  = 1'b0;
        pc_next = '0;
        #1;
        chk("rst_busy",    32'(busy),     32'd1);
        chk("rst_pc",      pc,            32'hA000_0000);
        chk("rst_rd0",     rd_data[31:0], 32'd0);
        chk("rst_illegal", 32'(illegal),  32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Clear phase: writes attempted every cycle must be dropped.
        set_rd(5'd5, 5'd0);
        wr_en   = 1'b1;
        wr_idx  = 5'd5;
        wr_data = 32'hFFFF;
        for (int i = 0; i < 24; i++) begin
            chk($sformatf("clr_busy_%0d", i), 32'(busy), 32'd1);
            step();
            chk($sformatf("clr_rd_%0d", i), rd_data[31:0], 32'd0);
        end
        chk("clr_done_busy", 32'(busy), 32'd0);
        wr_en = 1'b0;
        step();
        chk("post_clr_r5", rd_data[31:0], 32'd0);
        chk("post_clr_ill", 32'(illegal), 32'd0);

        // Banking.
        rb = 1'b0; wr(5'd2, 32'h1111);
        rb = 1'b1; wr(5'd2, 32'h2222);
        wr(5'd10, 32'hAAAA);
        rb = 1'b0; set_rd(5'd2, 5'd18); step();
        chk("rb0_r2",      rd_data[31:0],  32'h1111);
        chk("rb0_r2bank",  rd_data[63:32], 32'h2222);
        rb = 1'b1; step();
        chk("rb1_r2",      rd_data[31:0],  32'h2222);
        chk("rb1_r2bank",  rd_data[63:32], 32'h1111);
        rb = 1'b0; set_rd(5'd10, 5'd0); step();
        chk("rb0_r10", rd_data[31:0], 32'hAAAA);
        rb = 1'b1; step();
        chk("rb1_r10", rd_data[31:0], 32'hAAAA);

        // Bypass.
        rb = 1'b0; wr(5'd6, 32'h6666);
        set_rd(5'd7, 5'd6);
        wr(5'd7, 32'hDEAD);
        chk("byp_p0", rd_data[31:0],  32'hDEAD);
        chk("byp_p1", rd_data[63:32], 32'h6666);
        step();
        chk("arr_r7", rd_data[31:0], 32'hDEAD);
        // Bypass on a banked slot: R3_BANK written and read in the same cycle.
        set_rd(5'd3, 5'd19);
        wr(5'd19, 32'h1919);
        chk("byp_bank_p1", rd_data[63:32], 32'h1919);
        chk("byp_bank_p0", rd_data[31:0],  32'd0);

        // Illegal indices.
        set_rd(5'd24, 5'd0); step();
        chk("ill_rd_pulse", 32'(illegal),  32'd1);
        chk("ill_rd_data",  rd_data[31:0], 32'd0);
        set_rd(5'd0, 5'd2); step();
        chk("ill_rd_clear", 32'(illegal), 32'd0);
        wr(5'd31, 32'hFFFF);
        chk("ill_wr_pulse", 32'(illegal), 32'd1);
        step();
        chk("ill_wr_clear", 32'(illegal),  32'd0);
        chk("ill_wr_r0",    rd_data[31:0],  32'd0);
        chk("ill_wr_r2",    rd_data[63:32], 32'h1111);
        rb = 1'b1; set_rd(5'd7, 5'd11); step();
        chk("ill_wr_slot23", rd_data[31:0],  32'd0);
        chk("ill_wr_r11",    rd_data[63:32], 32'd0);

        // Program counter.
        chk("pc_hold", pc, 32'hA000_0000);
        pc_inc = 1'b1;
        step(); step(); step();
        chk("pc_inc3", pc, 32'hA000_0006);
        pc_load = 1'b1; pc_next = 32'hFFFF_FFFE; step();
        chk("pc_load_prio", pc, 32'hFFFF_FFFE);
        pc_load = 1'b0; step();
        chk("pc_wrap", pc, 32'd0);
        pc_inc = 1'b0;

        // Reset during RUN.
        reset = 1'b1;
        #1;
        chk("rrst_pc",   pc,              32'hA000_0000);
        chk("rrst_busy", 32'(busy),       32'd1);
        chk("rrst_rd1",  rd_data[63:32],  32'd0);
        step();
        reset = 1'b0;
        cyc = 0;
        while (busy && cyc < 40) begin
            step();
            cyc++;
        end
        chk("rrst_busy_done", 32'(busy), 32'd0);
        chk("rrst_clr_len",   32'(cyc),  32'd24);
        rb = 1'b0; set_rd(5'd2, 5'd18); step();
        chk("rrst_r2_b0", rd_data[31:0],  32'd0);
        chk("rrst_r2_b1", rd_data[63:32], 32'd0);
        set_rd(5'd10, 5'd7); step();
        chk("rrst_r10", rd_data[31:0],  32'd0);
        chk("rrst_r7",  rd_data[63:32], 32'd0);
        set_rd(5'd6, 5'd19); step();
        chk("rrst_r6",      rd_data[31:0],  32'd0);
        chk("rrst_r3bank",  rd_data[63:32], 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sh4a_banked_regfile.md
# sh4a_banked_regfile

Parametrised SH-4A general-register file with hardware register banking, N read ports, write-to-read bypass, a post-reset clear sequencer and a program counter with increment/load. It sits between the decode stage and the execute stage of the SH-4A core. Decode presents logical register indices plus the current SR.RB bank bit; the block maps them onto 24 physical registers and returns registered operands one cycle later.

## Interface
- `DATA_W`, 32, register and PC width.
- `NUM_RD`, 2, number of read ports (1..4).
- `RESET_PC`, 32'hA000_0000, PC value on reset.
- `clk` in 1: single clock; all state is updated on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `rb` in 1: current SR.RB bank select.
- `rd_idx` in 5*NUM_RD: per-port logical index. Bit 4 = 0 selects R0..R15 through `rb`. Bit 4 = 1 selects Rn_BANK of the opposite bank, n = bits 2:0. Bit 4 = 1 with bit 3 = 1 is illegal.
- `rd_data` out DATA_W*NUM_RD: registered read data; port k occupies bits [k*DATA_W +: DATA_W].
- `wr_en` in 1: write request.
- `wr_idx` in 5: logical write index; same encoding as `rd_idx`.
- `wr_data` in DATA_W: write data.
- `pc_load` in 1: load `pc_next` into the PC.
- `pc_inc` in 1: advance the PC by 2.
- `pc_next` in DATA_W: branch target.
- `pc` out DATA_W: current PC.
- `busy` out 1: clear sequencer active; the core must stall while it is high.
- `illegal` out 1: one-cycle registered pulse when any read or write request in the previous cycle used an illegal index.

## Operation
- Physical map, with n = idx[2:0]:
  - idx < 8: physical n + 16*(rb ^ idx[4]).
  - 8 ≤ idx ≤ 15: physical idx (global registers).
  - idx in 16..23: physical n + 16*(!rb).
  - Physical slots 0..7 are bank 0, 8..15 are the globals, 16..23 are bank 1.
- State machine: `CLEAR` → `RUN`.
  - Asynchronous reset forces `CLEAR` with clear counter 0.
  - In `CLEAR`, one physical register (counter value) is written with 0 per cycle. When the counter reaches 23 it writes that slot and the state moves to `RUN`.
  - In `CLEAR`, `wr_en` is ignored, `rd_data` is held at 0 and `illegal` stays 0.
  - `RUN` persists until the next reset.
- Reads in `RUN`: every port registers the contents of its mapped physical register. Illegal indices return 0.
- Bypass: if `wr_en` is set and the mapped write target equals a read port's mapped source in the same cycle, that port registers `wr_data`. Matching is on physical index, so R3 with rb=1 and R3_BANK with rb=0 hit the same slot.
- Writes: an illegal `wr_idx` does not modify any register.
- PC:
  - `pc_load` has priority over `pc_inc`.
  - Increment is modulo 2^DATA_W; 32'hFFFF_FFFE wraps to 0.
  - The PC updates in both `CLEAR` and `RUN`.
- A change of `rb` affects only requests sampled on the same edge; there is no stored bank state.

## Timing
- Reset values: `rd_data` 0, `pc` RESET_PC, `busy` 1, `illegal` 0, state `CLEAR`, counter 0.
- `busy` is combinational from the state: it stays high for exactly 24 rising edges after reset deasserts and falls after the edge that clears slot 23.
- Read latency: 1 cycle. A write is visible to a read issued in the same cycle through the bypass. Reads in any later cycle see it from the array.
- `illegal` is asserted in the cycle after the offending request, for 1 cycle.
- Reset asserted mid-clear or mid-run: the state machine returns immediately to `CLEAR` with counter 0, and all outputs take their reset values asynchronously.

## Structure
- Shared package `sh4a_pkg` holds:
  - `SH4A_RESET_PC`;
  - physical-slot constants: BANK0_BASE 0, GLOBAL_BASE 8, BANK1_BASE 16, NUM_PHYS 24;
  - the `regfile_state_t` enum {CLEAR, RUN}.
- Sub-module `sh4a_bank_map`: combinational logical→physical mapper with inputs idx and rb, outputs a 5-bit phys index and a legal flag. Instantiate it NUM_RD+1 times.
- Storage is a 24×DATA_W flop array with no memory inference, since it must be cleared.

## Test plan
- Reset release then 24 cycles with `wr_en`=1 → `busy` stays high for 24 edges; all writes are dropped and `rd_data` reads 0 throughout. After `busy` falls, a read of R5 returns 0.
- rb=0: write R2=32'h1111, then rb=1: write R2=32'h2222. Read R2 with rb=0 → 32'h1111; read R2_BANK (idx 18) with rb=0 → 32'h2222. Read R10 with rb=0 and rb=1 → same value.
- Same cycle: `wr_en`, R7 ← 32'hDEAD, with port 0 reading R7 and port 1 reading R6 → next cycle port0 = 32'hDEAD and port1 = the old R6.
- Read idx 24, and separately write idx 31 with data 32'hFFFF → `illegal` pulses 1 cycle each; the read returns 0 and no register changes.
- `pc_inc` from RESET_PC for 3 cycles → A000_0006. Then `pc_load`+`pc_inc` with target 32'hFFFF_FFFE → FFFF_FFFE. Then `pc_inc` → 0.
- Assert reset for 1 cycle during RUN after writes → `pc` = A000_0000 and `busy` = 1 immediately. After the clear completes, every previously written register reads 0.
